gray_decode_seq: RTL and testbench

Sequential Gray-to-binary decoder: the receiving end of the team's binary-to-Gray encoder path. It accepts one Gray-coded word per valid/ready handshake, resolves it MSB-first one bit per clock, and presents the binary result on a valid/ready output port. It also flags any decoded value that is not a single-step move (0, +1 or −1 modulo 2^DATA_LEN) from the previous result. The block sits after Gray-coded counter samplers and position sources.

---
 rtl/gray_decode_seq_if.sv | 23 ++
 rtl/gray_decode_seq.sv | 99 +++++++++
 tb/tb_gray_decode_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_decode_seq_if.sv
// Handshake bundle for the sequential Gray decoder: one Gray word in, one
// binary result (with step-distance flag) out, each on a valid/ready pair.
interface gray_decode_seq_if #(
  parameter int DATA_LEN = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_gray;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_bin;
  logic                dist_err;

  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, dist_err
  );

  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, dist_err
  );
endinterface

// File: rtl/gray_decode_seq.sv
// Sequential Gray-to-binary decoder: resolves one bit per clock MSB-first and
// flags results that are not a 0/+1/-1 (mod 2^DATA_LEN) step from the last one.
module gray_decode_seq #(
  parameter int DATA_LEN = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_decode_seq_if.slave   bus
);

  localparam int                IDX_W   = $clog2(DATA_LEN);
  localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(DATA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_LEN-1:0] gray_q;
  logic [DATA_LEN-1:0] bin_q, bin_d, bin_shr;
  logic [DATA_LEN-1:0] prev_q;
  logic [DATA_LEN-1:0] diff;
  logic [IDX_W-1:0]    idx_q;
  logic                have_prev_q;
  logic                err_q, err_d;
  logic                accept, release_out, last_bit;

  assign accept      = (state_q == IDLE) && bus.in_valid;
  assign release_out = (state_q == DONE) && bus.out_ready;
  assign last_bit    = (state_q == BUSY) && (idx_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)      state_d = BUSY;
      BUSY: if (last_bit)    state_d = DONE;
      DONE: if (release_out) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from state only: no in_valid/out_ready feedthrough.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Shifting right lines bin[j+1] up with bit j; at the MSB the shifted-in
  // zero makes bin[MSB] = g[MSB] without a special case.
  assign bin_shr = bin_q >> 1;

  always_comb begin
    bin_d        = bin_q;
    bin_d[idx_q] = bin_shr[idx_q] ^ gray_q[idx_q];
    diff         = bin_d - prev_q;
    err_d        = have_prev_q &&
                   !((diff == '0) || (diff == DATA_LEN'(1)) || (diff == '1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q      <= '0;
      bin_q       <= '0;
      prev_q      <= '0;
      idx_q       <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        gray_q <= bus.in_gray;
        idx_q  <= IDX_MSB;
      end
      if (state_q == BUSY) begin
        bin_q <= bin_d;
        idx_q <= idx_q - IDX_W'(1);
      end
      if (last_bit) err_q <= err_d;
      if (release_out) begin
        prev_q      <= bin_q;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign bus.out_bin  = bin_q;
  assign bus.dist_err = err_q;

endmodule

// File: tb/tb_gray_decode_seq.sv
// Self-checking bench for gray_decode_seq at DATA_LEN=5 and DATA_LEN=8,
// directed cases plus random words against an arithmetic reference model.
module tb_gray_decode_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int   prev_m [2];
  bit   have_m [2];

  gray_decode_seq_if #(.DATA_LEN(5)) b5 ();
  gray_decode_seq_if #(.DATA_LEN(8)) b8 ();

  gray_decode_seq #(.DATA_LEN(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  gray_decode_seq #(.DATA_LEN(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Binary is the XOR of all right-shifts of the Gray word.
  function automatic int gray2bin(input int g, input int n);
    int b = 0;
    for (int s = 0; s < n; s++) b ^= (g >> s);
    return b & ((1 << n) - 1);
  endfunction

  function automatic bit is_jump(input int b, input int p, input int n);
    int m = 1 << n;
    int d = (((b - p) % m) + m) % m;
    return !((d == 0) || (d == 1) || (d == m - 1));
  endfunction

  task automatic set_in(input bit w8, input bit v, input int g, input bit r);
    if (w8) begin
      b8.in_valid = v; b8.in_gray = 8'(g); b8.out_ready = r;
    end else begin
      b5.in_valid = v; b5.in_gray = 5'(g); b5.out_ready = r;
    end
  endtask

  function automatic logic [31:0] rd_bin(input bit w8);
    return w8 ? 32'(b8.out_bin) : 32'(b5.out_bin);
  endfunction
  function automatic logic [31:0] rd_err(input bit w8);
    return w8 ? 32'(b8.dist_err) : 32'(b5.dist_err);
  endfunction
  function automatic logic [31:0] rd_ov(input bit w8);
    return w8 ? 32'(b8.out_valid) : 32'(b5.out_valid);
  endfunction
  function automatic logic [31:0] rd_ir(input bit w8);
    return w8 ? 32'(b8.in_ready) : 32'(b5.in_ready);
  endfunction

  // One word through the selected DUT; optionally stalls DONE for 'stall' cycles.
  task automatic xfer(input bit w8, input int g, input int stall,
                      output logic [31:0] got_bin, output logic [31:0] got_err);
    int n   = w8 ? 8 : 5;
    int cyc = 0;
    int exp_bin, exp_err;
    @(negedge clk);
    check("in_ready_idle", rd_ir(w8), 1);
    set_in(w8, 1'b1, g, stall == 0);
    @(posedge clk);
    @(negedge clk);
    set_in(w8, 1'b0, int'($urandom), stall == 0);
    while (rd_ov(w8) !== 1 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      set_in(w8, 1'($urandom_range(0, 1)), int'($urandom), stall == 0);
      cyc++;
    end
    set_in(w8, 1'b0, 0, stall == 0);
    check("latency", cyc, n);
    exp_bin = gray2bin(g, n);
    exp_err = int'(have_m[w8] && is_jump(exp_bin, prev_m[w8], n));
    got_bin = rd_bin(w8);
    got_err = rd_err(w8);
    check("out_bin", got_bin, exp_bin);
    check("dist_err", got_err, exp_err);
    for (int s = 0; s < stall; s++) begin
      set_in(w8, 1'($urandom_range(0, 1)), int'($urandom), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("stall_in_ready", rd_ir(w8), 0);
      check("stall_out_valid", rd_ov(w8), 1);
      check("stall_out_bin", rd_bin(w8), exp_bin);
      check("stall_dist_err", rd_err(w8), exp_err);
    end
    set_in(w8, 1'b0, 0, 1'b1);
    prev_m[w8] = exp_bin;
    have_m[w8] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", rd_ov(w8), 0);
    check("post_in_ready", rd_ir(w8), 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", rd_ir(0), 1);
    check("rst_out_valid", rd_ov(0), 0);
    check("rst_out_bin", rd_bin(0), 0);
    check("rst_dist_err", rd_err(0), 0);
    check("rst8_out_valid", rd_ov(1), 0);
    have_m[0] = 1'b0; have_m[1] = 1'b0;
    prev_m[0] = 0;    prev_m[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] gb, ge;
    int          gi;
    rst_n = 1'b0;
    set_in(0, 1'b0, 0, 1'b0);
    set_in(1, 1'b0, 0, 1'b0);
    have_m[0] = 1'b0; have_m[1] = 1'b0;
    prev_m[0] = 0;    prev_m[1] = 0;
    #1;
    check("init_in_ready", rd_ir(0), 1);
    check("init_out_valid", rd_ov(0), 0);
    check("init_out_bin", rd_bin(0), 0);
    check("init_dist_err", rd_err(0), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic decode, single step, then a jump of 2.
    xfer(0, 5'b10011, 0, gb, ge);
    check("basic_bin", gb, 29);
    check("basic_err", ge, 0);
    xfer(0, 5'b10001, 0, gb, ge);
    check("step_bin", gb, 30);
    check("step_err", ge, 0);
    xfer(0, 5'b00000, 0, gb, ge);
    check("jump_bin", gb, 0);
    check("jump_err", ge, 1);

    // Wrap-around in both directions.
    xfer(0, 5'b10000, 0, gb, ge);
    check("wrap_a_bin", gb, 31);
    check("wrap_a_err", ge, 0);
    xfer(0, 5'b00000, 0, gb, ge);
    check("wrap_b_bin", gb, 0);
    check("wrap_b_err", ge, 0);
    xfer(0, 5'b10000, 0, gb, ge);
    check("wrap_c_bin", gb, 31);
    check("wrap_c_err", ge, 0);

    // Backpressure with input noise, then a word proving nothing was captured.
    xfer(0, 5'b00001, 10, gb, ge);
    check("bp_bin", gb, 1);
    check("bp_err", ge, 1);
    xfer(0, 5'b00001, 0, gb, ge);
    check("bp_next_bin", gb, 1);
    check("bp_next_err", ge, 0);

    // Reset on BUSY cycle 2, prev nonadjacent to the following word.
    xfer(0, 5'b11000, 0, gb, ge);
    @(negedge clk);
    set_in(0, 1'b1, 5'b10000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", rd_ov(0), 0);
    check("midrst_in_ready", rd_ir(0), 1);
    check("midrst_out_bin", rd_bin(0), 0);
    have_m[0] = 1'b0; have_m[1] = 1'b0;
    prev_m[0] = 0;    prev_m[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 5'b00000, 0, gb, ge);
    check("midrst_next_bin", gb, 0);
    check("midrst_next_err", ge, 0);

    // Random words with random stalls.
    for (int k = 0; k < 30; k++) begin
      xfer(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), gb, ge);
    end

    // Exhaustive Gray sweeps, wrapping back to zero.
    apply_reset();
    for (int i = 0; i <= 32; i++) begin
      gi = i % 32;
      xfer(0, gi ^ (gi >> 1), 0, gb, ge);
      check("sweep5_bin", gb, gi);
      check("sweep5_err", ge, 0);
    end
    for (int i = 0; i <= 256; i++) begin
      gi = i % 256;
      xfer(1, gi ^ (gi >> 1), 0, gb, ge);
      check("sweep8_bin", gb, gi);
      check("sweep8_err", ge, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
